// File: rtl/noc_router_input_route.sv
// Input-port front end of a mesh NoC router.
// Incoming link flits are buffered in a small FIFO. The head-of-queue flit is
// offered to the forward/backward pipeline stage together with a one-hot
// output-port request. Head flits are XY-routed from their header
// (dest_x in the low XW bits, dest_y in the next YW bits). Every body flit
// reuses the route latched when its head was transferred, until the packet's
// last flit leaves.
// Output port numbering: 0 local, 1 north, 2 east, 3 south, 4 west.

module noc_router_input_route #(
    parameter int DATA_WIDTH   = 256,
    parameter int OUTPUTS      = 5,
    parameter int BUFFER_DEPTH = 4,
    parameter int XW           = 4,
    parameter int YW           = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XW-1:0]         my_x,
    input  logic [YW-1:0]         my_y,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic [OUTPUTS-1:0]    out_valid,
    input  logic                  out_ready
);

    // Pointer and occupancy widths; the count has one extra bit so that a
    // full FIFO and an empty FIFO are distinguishable.
    localparam int AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Output port indices inside the one-hot request vector.
    localparam int P_LOCAL = 0;
    localparam int P_NORTH = 1;
    localparam int P_EAST  = 2;
    localparam int P_SOUTH = 3;
    localparam int P_WEST  = 4;

    typedef enum logic {
        S_HEAD = 1'b0,
        S_BODY = 1'b1
    } state_t;

    // Dimension-ordered XY routing: resolve X first, then Y, else eject
    // locally. Unsigned comparisons; the result is always exactly one-hot.
    function automatic logic [OUTPUTS-1:0] xy_route(
        input logic [XW-1:0] dest_x,
        input logic [YW-1:0] dest_y,
        input logic [XW-1:0] cur_x,
        input logic [YW-1:0] cur_y
    );
        logic [OUTPUTS-1:0] r;
        r = {OUTPUTS{1'b0}};
        if (dest_x > cur_x) begin
            r[P_EAST] = 1'b1;
        end else if (dest_x < cur_x) begin
            r[P_WEST] = 1'b1;
        end else if (dest_y > cur_y) begin
            r[P_NORTH] = 1'b1;
        end else if (dest_y < cur_y) begin
            r[P_SOUTH] = 1'b1;
        end else begin
            r[P_LOCAL] = 1'b1;
        end
        return r;
    endfunction

    // FIFO storage: each entry is {last, flit}. Storage is deliberately not
    // reset; validity is tracked solely by the count.
    logic [DATA_WIDTH:0] mem_q [BUFFER_DEPTH];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    state_t             state_q, state_d;
    logic [OUTPUTS-1:0] route_q, route_d;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_WIDTH:0]   head_entry_s;
    logic                  head_last_s;
    logic [OUTPUTS-1:0]    head_route_s;
    logic [OUTPUTS-1:0]    out_valid_s;

    // FIFO status and the decoded route of the current head entry.
    always_comb begin
        full_s       = (count_q == CW'(BUFFER_DEPTH));
        empty_s      = (count_q == {CW{1'b0}});
        head_entry_s = mem_q[rd_ptr_q];
        head_last_s  = head_entry_s[DATA_WIDTH];
        head_route_s = xy_route(head_entry_s[XW-1:0],
                                head_entry_s[XW+YW-1:XW],
                                my_x, my_y);
    end

    // Request vector: decoded route for a head flit, latched route for body
    // flits, nothing while the FIFO is empty (also mid-packet).
    always_comb begin
        out_valid_s = {OUTPUTS{1'b0}};
        case (state_q)
            S_HEAD: begin
                if (empty_s) begin
                    out_valid_s = {OUTPUTS{1'b0}};
                end else begin
                    out_valid_s = head_route_s;
                end
            end
            S_BODY: begin
                if (empty_s) begin
                    out_valid_s = {OUTPUTS{1'b0}};
                end else begin
                    out_valid_s = route_q;
                end
            end
            default: begin
                out_valid_s = {OUTPUTS{1'b0}};
            end
        endcase
    end

    // Handshakes. A push is refused whenever the FIFO is full, even if a pop
    // frees an entry in the same cycle; out_ready is ignored with no request.
    always_comb begin
        push_s = in_valid && !full_s;
        pop_s  = (|out_valid_s) && out_ready;
    end

    // Pointer and occupancy update; simultaneous push and pop keep the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Packet FSM: a non-last head transfer latches its route and enters the
    // body phase; the last flit of a packet returns to head decoding.
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            S_HEAD: begin
                if (pop_s && !head_last_s) begin
                    route_d = head_route_s;
                    state_d = S_BODY;
                end else begin
                    route_d = route_q;
                    state_d = S_HEAD;
                end
            end
            S_BODY: begin
                if (pop_s && head_last_s) begin
                    state_d = S_HEAD;
                end else begin
                    state_d = S_BODY;
                end
            end
            default: begin
                state_d = S_HEAD;
                route_d = {OUTPUTS{1'b0}};
            end
        endcase
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            state_q  <= S_HEAD;
            route_q  <= {OUTPUTS{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            route_q  <= route_d;
        end
    end

    // FIFO storage write on an accepted push.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_last, in_flit};
        end
    end

    // Ready is held low while reset is asserted.
    assign in_ready  = !rst && !full_s;
    assign out_flit  = head_entry_s[DATA_WIDTH-1:0];
    assign out_last  = head_last_s;
    assign out_valid = out_valid_s;

endmodule

// File: tb/tb_noc_router_input_route.sv
// Randomized scoreboard bench for noc_router_input_route.
module tb_noc_router_input_route;

    localparam int DW = 256;
    localparam int NO = 5;
    localparam int D  = 4;
    localparam int XW = 4;
    localparam int YW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [XW-1:0] my_x = 4'd0;
    logic [YW-1:0] my_y = 4'd0;
    logic [DW-1:0] in_flit = '0;
    logic          in_last = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_flit;
    logic          out_last;
    logic [NO-1:0] out_valid;
    logic          out_ready = 1'b0;

    noc_router_input_route #(
        .DATA_WIDTH(DW), .OUTPUTS(NO), .BUFFER_DEPTH(D), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .rst(rst), .my_x(my_x), .my_y(my_y),
        .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid),
        .in_ready(in_ready), .out_flit(out_flit), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] flit;
        logic          last;
        logic [NO-1:0] route;
    } exp_t;

    exp_t          exp_q[$];
    bit            model_head = 1'b1;
    logic [NO-1:0] model_route = '0;
    bit            pend_push = 1'b0;
    bit            rand_mode = 1'b0;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // XY route from the rules: X first, then Y, else local.
    function automatic logic [NO-1:0] ref_route(int dx, int dy, int mx, int my);
        if (dx > mx) return 5'b00100;
        if (dx < mx) return 5'b10000;
        if (dy > my) return 5'b00010;
        if (dy < my) return 5'b01000;
        return 5'b00001;
    endfunction

    function automatic logic [DW-1:0] rand_flit(int dx, int dy);
        logic [DW-1:0] f;
        for (int w = 0; w < DW / 32; w++) f[w*32 +: 32] = $urandom;
        f[3:0] = 4'(dx);
        f[7:4] = 4'(dy);
        return f;
    endfunction

    // Drive one flit until accepted; the expectation is queued on acceptance.
    task automatic send(input logic [DW-1:0] f, input logic l);
        bit acc;
        exp_t e;
        acc = 1'b0;
        in_flit  = f;
        in_last  = l;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1'b1;
                if (model_head) model_route = ref_route(int'(f[3:0]), int'(f[7:4]), int'(my_x), int'(my_y));
                e.flit  = f;
                e.last  = l;
                e.route = model_route;
                exp_q.push_back(e);
                model_head = l;
                pend_push  = 1'b1;
            end
            @(posedge clk);
            #1;
            pend_push = 1'b0;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got not-accepted expected accepted");
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rand_mode) out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", DW'(exp_q.size()), DW'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(0));
        exp_q.delete();
        model_head = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", DW'(in_ready), DW'(1));
    endtask

    // Monitor: every cycle compare the handshake state and the head entry
    // with the model, and retire the expectation when a pop happens.
    always @(negedge clk) begin
        int occ;
        #1;
        if (!rst) begin
            occ = exp_q.size() - (pend_push ? 1 : 0);
            check("in_ready", DW'(in_ready), DW'(occ < D));
            check("out_valid_any", DW'(|out_valid), DW'(occ > 0));
            if (occ > 0) begin
                check("out_valid_route", DW'(out_valid), DW'(exp_q[0].route));
                check("out_flit", out_flit, exp_q[0].flit);
                check("out_last", DW'(out_last), DW'(exp_q[0].last));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2;
        do_reset();

        // Single local flit.
        my_x = 4'd2; my_y = 4'd2;
        send(rand_flit(2, 2), 1'b1);
        #1;
        check("single_local", DW'(out_valid), DW'(5'b00001));
        drain();
        check("after_single_idle", DW'(out_valid), DW'(0));

        // 3-flit packet east; body header bits must not be re-decoded.
        my_x = 4'd1; my_y = 4'd1;
        send(rand_flit(3, 0), 1'b0);
        send(rand_flit(0, 1), 1'b0);
        send(rand_flit(1, 3), 1'b1);
        drain();
        send(rand_flit(1, 3), 1'b1);
        send(rand_flit(0, 3), 1'b1);
        drain();

        // Backpressure: fill, hold, then simultaneous full push/pop.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rand_flit(i, 3 - i), i == 3);
        cycles(3);
        check("full_in_ready", DW'(in_ready), DW'(0));
        out_ready = 1'b1;
        send(rand_flit(2, 2), 1'b1);
        send(rand_flit(0, 0), 1'b1);
        drain();

        // Empty mid-packet: body arrives later and keeps the route.
        send(rand_flit(1, 0), 1'b0);
        cycles(3);
        check("mid_pkt_empty", DW'(out_valid), DW'(0));
        send(rand_flit(3, 3), 1'b1);
        drain();

        // Reset in the middle of a 4-flit packet.
        out_ready = 1'b0;
        send(rand_flit(3, 0), 1'b0);
        send(rand_flit(2, 2), 1'b0);
        send(rand_flit(2, 2), 1'b0);
        send(rand_flit(2, 2), 1'b1);
        out_ready = 1'b1;
        cycles(2);
        out_ready = 1'b0;
        do_reset();
        send(rand_flit(0, 1), 1'b1);
        #1;
        check("post_rst_west", DW'(out_valid), DW'(5'b10000));
        drain();

        // Randomized packets with random backpressure and gaps.
        rand_mode = 1'b1;
        for (int r = 0; r < 4; r++) begin
            my_x = 4'($urandom_range(0, 15));
            my_y = 4'($urandom_range(0, 15));
            for (int p = 0; p < 10; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    send(rand_flit($urandom_range(0, 15), $urandom_range(0, 15)), k == len - 1);
                    if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
                end
            end
            rand_mode = 1'b0;
            drain();
            rand_mode = 1'b1;
        end
        rand_mode = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
